// File: rtl/i2c_target_regfile.sv
`timescale 1ns/1ps
// I2C target with a byte-wide register file, oversampled on clk (no clock stretching).
// Registers are written over the bus and exposed in parallel, with a strobe per committed write.
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR  = 7'h3C,
    parameter int unsigned REG_COUNT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scl,
    inout  wire                    sda,
    output logic [REG_COUNT*8-1:0] regs,
    output logic                   wr_strobe,
    output logic [7:0]             wr_addr,
    output logic [7:0]             wr_data,
    output logic                   busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, RACK, IGNORE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  ptr, ptr_nxt;
    logic        sda_oe, sda_oe_nxt;
    logic        rw, rw_nxt;
    logic        busy_nxt, strobe_nxt;
    logic [7:0]  wr_addr_nxt, wr_data_nxt;
    logic        we;
    logic [7:0]  rd_byte;
    logic [7:0]  shifted;
    logic        ptr_ok;
    logic [7:0]  mem [REG_COUNT];

    logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    // Sync FFs reset to the idle-bus level so no edge is seen on reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {scl_s1, scl_s2, scl_h} <= '1;
            {sda_s1, sda_s2, sda_h} <= '1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    // The bus is released combinationally on the clk that detects START/STOP.
    assign sda = (sda_oe && !start_det && !stop_det) ? 1'b0 : 1'bz;

    assign shifted = {shreg[6:0], sda_s2};
    assign ptr_ok  = ({24'd0, ptr} < REG_COUNT);

    always_comb begin
        rd_byte = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++)
            if (ptr == 8'(i)) rd_byte = mem[i];
    end

    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++)
            regs[i*8 +: 8] = mem[i];
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        sda_oe_nxt  = sda_oe;
        rw_nxt      = rw;
        busy_nxt    = busy;
        strobe_nxt  = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        we          = 1'b0;
        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = shifted;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_nxt = '0;
                            if (state == ADDR) begin
                                // General call only matches when DEV_ADDR is zero.
                                rw_nxt    = sda_s2;
                                state_nxt = (shifted[7:1] == DEV_ADDR) ? ACK_ADDR : IGNORE;
                            end else if (state == PTR) begin
                                ptr_nxt   = shifted;
                                state_nxt = ACK_PTR;
                            end else begin
                                we          = ptr_ok;
                                strobe_nxt  = ptr_ok;
                                if (ptr_ok) begin
                                    wr_addr_nxt = ptr;
                                    wr_data_nxt = shifted;
                                end
                                ptr_nxt   = ptr + 8'd1;
                                state_nxt = ACK_WDATA;
                            end
                        end
                    end
                end
                // First scl fall starts the ACK drive, the second one ends it.
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                        end else if (rw) begin
                            shreg_nxt   = rd_byte;
                            sda_oe_nxt  = ~rd_byte[7];
                            bit_cnt_nxt = '0;
                            state_nxt   = RDATA;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = PTR;
                        end
                    end
                end
                ACK_PTR, ACK_WDATA: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = 1'b1;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_nxt  = 1'b0;
                            ptr_nxt     = ptr + 8'd1;
                            bit_cnt_nxt = '0;
                            state_nxt   = RACK;
                        end else begin
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            sda_oe_nxt = ~shreg[6];
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda_s2) state_nxt = IGNORE;
                        else        bit_cnt_nxt = 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        shreg_nxt   = rd_byte;
                        sda_oe_nxt  = ~rd_byte[7];
                        bit_cnt_nxt = '0;
                        state_nxt   = RDATA;
                    end
                end
                IGNORE:  sda_oe_nxt = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            ptr       <= ptr_nxt;
            sda_oe    <= sda_oe_nxt;
            rw        <= rw_nxt;
            busy      <= busy_nxt;
            wr_strobe <= strobe_nxt;
            wr_addr   <= wr_addr_nxt;
            wr_data   <= wr_data_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) mem[i] <= '0;
        end else if (we) begin
            for (int unsigned i = 0; i < REG_COUNT; i++)
                if (ptr == 8'(i)) mem[i] <= shifted;
        end
    end

endmodule
